enc_seq_ctrl: RTL and testbench

Parametrised sequencer for the matrix encoder datapath. Each element is a read → load → write cycle over a run of `len` elements. It drives the source-memory read, the input-register load and the destination write. It owns its own element index counter and tolerates multi-cycle memory read latency and write back-pressure. It sits between the top-level start/done handshake and the encoder datapath, and replaces the fixed single-cycle-read controller.

---
 rtl/enc_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_enc_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_seq_ctrl.sv
// enc_seq_ctrl: sequences the matrix encoder datapath through read -> load -> write
// for each element of a run of `len` elements. Tolerates multi-cycle source-memory
// read latency (RD_LAT) and back-pressure on the destination write (wr_ready).
module enc_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    input  logic              wr_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              inreg_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    // WAIT lasts RD_LAT-1 cycles: the counter starts at RD_LAT-2 and exits at zero.
    localparam logic [1:0]        LAT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [1:0]        lat_q, lat_d;

    // State, element index, captured length and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            lat_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state logic; abort overrides every transition of an active run.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        len_d   = len;
                        idx_d   = '0;
                        state_d = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                if (RD_LAT == 1) begin
                    state_d = S_LOAD;
                end else begin
                    lat_d   = LAT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_q == 2'd0) begin
                    state_d = S_LOAD;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_LOAD: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (wr_ready) begin
                    if (idx_q == len_q - ONE) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + ONE;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d = S_IDLE;
            idx_d   = idx_q;
            lat_d   = lat_q;
        end
    end

    assign rd_en    = (state_q == S_READ);
    assign inreg_en = (state_q == S_LOAD);
    assign wr_en    = (state_q == S_WRITE);
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE);
    assign rd_addr  = idx_q;
    assign wr_addr  = idx_q;

endmodule

// File: tb/tb_enc_seq_ctrl.sv
// Testbench for enc_seq_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share start/len/abort.
// A run-level model predicts every strobe event; a negedge monitor pops and compares.
module tb_enc_seq_ctrl;

    localparam int AW   = 8;
    localparam int MAXC = 4096;

    typedef struct {
        int kind;
        int addr;
        int acc;
        int cyc;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] len;
    logic          abort;
    logic [1:0]    wrReady;
    logic [1:0]    rdEn, inregEn, wrEn, busy, doneSig;
    logic [AW-1:0] rdAddr [2];
    logic [AW-1:0] wrAddr [2];

    int  errors  = 0;
    int  checks  = 0;
    int  edgeCnt = 0;
    ev_t expQ0[$];
    ev_t expQ1[$];
    int  wrSched [2][MAXC];
    int  stallCnt[2][256];

    enc_seq_ctrl #(.ADDR_W(AW), .RD_LAT(1)) dutLat1 (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .wr_ready(wrReady[0]), .rd_en(rdEn[0]), .rd_addr(rdAddr[0]),
        .inreg_en(inregEn[0]), .wr_en(wrEn[0]), .wr_addr(wrAddr[0]),
        .busy(busy[0]), .done(doneSig[0])
    );

    enc_seq_ctrl #(.ADDR_W(AW), .RD_LAT(3)) dutLat3 (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .wr_ready(wrReady[1]), .rd_en(rdEn[1]), .rd_addr(rdAddr[1]),
        .inreg_en(inregEn[1]), .wr_en(wrEn[1]), .wr_addr(wrAddr[1]),
        .busy(busy[1]), .done(doneSig[1])
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used as the time base for expected event cycles.
    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic ev_t mkEv(input int kind, input int addr, input int acc, input int cyc);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.acc  = acc;
        e.cyc  = cyc;
        return e;
    endfunction

    // Pop the next predicted event for one DUT and compare it with what was seen.
    task automatic observe(input int d, input int kind, input int addr, input int acc);
        ev_t e;
        int  present;
        present = (d == 0) ? expQ0.size() : expQ1.size();
        if (present == 0) begin
            checkOutput($sformatf("dut%0d unexpected event kind%0d", d, kind), 1, 0);
            return;
        end
        if (d == 0) e = expQ0.pop_front();
        else        e = expQ1.pop_front();
        checkOutput($sformatf("dut%0d event kind", d), kind, e.kind);
        checkOutput($sformatf("dut%0d event cycle kind%0d", d, e.kind), edgeCnt, e.cyc);
        checkOutput($sformatf("dut%0d event addr kind%0d", d, e.kind), addr, e.addr);
        checkOutput($sformatf("dut%0d write accepted", d), acc, e.acc);
    endtask

    // Monitor: every strobe seen at the falling edge is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (rdEn[d])    observe(d, 0, int'(rdAddr[d]), 0);
                if (inregEn[d]) observe(d, 1, int'(rdAddr[d]), 0);
                if (wrEn[d])    observe(d, 2, int'(wrAddr[d]), int'(wrReady[d] && !abort));
                if (doneSig[d]) observe(d, 3, 0, 0);
            end
        end
    end

    // Run-level model: element i occupies READ, lat-1 waits, LOAD, then WRITE until accepted.
    task automatic buildModel(input int d, input int lat, input int n, input int base,
                              input int abortCyc, output int endC);
        ev_t evs[$];
        ev_t e;
        int  t, w, doneC;
        t = 1;
        for (int i = 0; i < n; i++) begin
            evs.push_back(mkEv(0, i, 0, t));
            evs.push_back(mkEv(1, i, 0, t + lat));
            w = t + lat + 1;
            for (int j = 0; j < stallCnt[d][i]; j++) begin
                evs.push_back(mkEv(2, i, 0, w + j));
                wrSched[d][w + j] = 1;
            end
            w = w + stallCnt[d][i];
            evs.push_back(mkEv(2, i, 1, w));
            wrSched[d][w] = 2;
            t = w + 1;
        end
        doneC = t;
        evs.push_back(mkEv(3, 0, 0, doneC));
        endC = doneC;
        if (abortCyc > 0 && abortCyc < doneC) endC = abortCyc;
        foreach (evs[i]) begin
            e = evs[i];
            if (endC < doneC) begin
                if (e.cyc > endC) continue;
                if (e.cyc == endC) e.acc = 0;
            end
            e.cyc = e.cyc + base;
            if (d == 0) expQ0.push_back(e);
            else        expQ1.push_back(e);
        end
    endtask

    task automatic clearStalls();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) stallCnt[d][i] = 0;
    endtask

    task automatic clearSched();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < MAXC; k++) wrSched[d][k] = 0;
    endtask

    task automatic checkIdle(input int d, input string tag);
        checkOutput($sformatf("dut%0d %s busy", d, tag), int'(busy[d]), 0);
        checkOutput($sformatf("dut%0d %s strobes", d, tag),
                    int'(rdEn[d] | inregEn[d] | wrEn[d] | doneSig[d]), 0);
    endtask

    // Issue one run of n elements (abortCyc=0: no abort); junk start/len while busy.
    task automatic applyStimulus(input int n, input int abortCyc);
        int base, endC0, endC1, last, minEnd;
        clearSched();
        base  = edgeCnt;
        start = 1'b1;
        len   = AW'(n);
        abort = 1'b0;
        buildModel(0, 1, n, base, abortCyc, endC0);
        buildModel(1, 3, n, base, abortCyc, endC1);
        last   = (endC0 > endC1) ? endC0 : endC1;
        minEnd = (endC0 < endC1) ? endC0 : endC1;
        for (int k = 1; k <= last + 1; k++) begin
            @(posedge clk);
            #1;
            start = (k <= minEnd) ? 1'($urandom) : 1'b0;
            len   = AW'($urandom);
            abort = (k == abortCyc);
            for (int d = 0; d < 2; d++) begin
                case (wrSched[d][k])
                    1:       wrReady[d] = 1'b0;
                    2:       wrReady[d] = 1'b1;
                    default: wrReady[d] = 1'($urandom);
                endcase
            end
            @(negedge clk);
            if (k == endC0)     checkOutput("dut0 busy at run end", int'(busy[0]), 1);
            if (k == endC1)     checkOutput("dut1 busy at run end", int'(busy[1]), 1);
            if (k == endC0 + 1) checkIdle(0, "after run");
            if (k == endC1 + 1) checkIdle(1, "after run");
        end
        checkOutput("dut0 leftover events", expQ0.size(), 0);
        checkOutput("dut1 leftover events", expQ1.size(), 0);
        #1;
    endtask

    task automatic idleCycles(input int g);
        for (int i = 0; i < g; i++) begin
            @(posedge clk);
            #1;
            start   = 1'b0;
            abort   = 1'($urandom);
            wrReady = 2'($urandom);
        end
    endtask

    // Asynchronous reset in the middle of a run (RD_LAT=3 instance sits in WAIT).
    task automatic resetMidRun();
        int base, e0, e1;
        clearStalls();
        clearSched();
        base    = edgeCnt;
        start   = 1'b1;
        len     = AW'(3);
        abort   = 1'b0;
        wrReady = 2'b11;
        buildModel(0, 1, 3, base, 0, e0);
        buildModel(1, 3, 3, base, 0, e1);
        @(posedge clk);
        #1;
        start = 1'b1;
        len   = AW'(200);
        @(posedge clk);
        #1;
        start = 1'b0;
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkIdle(d, "mid-run reset");
            checkOutput($sformatf("dut%0d reset rd_addr", d), int'(rdAddr[d]), 0);
            checkOutput($sformatf("dut%0d reset wr_addr", d), int'(wrAddr[d]), 0);
        end
        #1 rst = 1'b0;
        expQ0.delete();
        expQ1.delete();
    endtask

    // Watchdog so a stuck run can never hang the simulation.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized runs.
    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        len     = '0;
        abort   = 1'b0;
        wrReady = 2'b00;
        clearStalls();
        clearSched();
        #2;
        for (int d = 0; d < 2; d++) begin
            checkIdle(d, "reset");
            checkOutput($sformatf("dut%0d reset rd_addr", d), int'(rdAddr[d]), 0);
            checkOutput($sformatf("dut%0d reset wr_addr", d), int'(wrAddr[d]), 0);
        end
        #10 rst = 1'b0;

        applyStimulus(3, 0);
        idleCycles(2);
        applyStimulus(2, 0);
        stallCnt[0][0] = 3;
        stallCnt[1][1] = 2;
        applyStimulus(2, 0);
        clearStalls();
        applyStimulus(0, 0);
        idleCycles(1);
        applyStimulus(4, 6);
        applyStimulus(1, 0);
        applyStimulus(255, 0);
        idleCycles(1);
        resetMidRun();
        applyStimulus(2, 0);

        for (int r = 0; r < 40; r++) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 256; i++)
                    stallCnt[d][i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            idleCycles(int'($urandom_range(0, 2)));
            applyStimulus(int'($urandom_range(0, 9)),
                          ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 40)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
